// File: rtl/elevator_timer_pkg.sv
// elevator_pkg: controller state type, door animation stage codes and the
// saturating add shared by the elevator timer blocks.
package elevator_pkg;

  typedef enum logic [1:0] {IDLE, RUN, OPEN, DONE} state_t;

  localparam logic [1:0] STAGE_CLOSED = 2'd0;
  localparam logic [1:0] STAGE_AJAR   = 2'd1;
  localparam logic [1:0] STAGE_HALF   = 2'd2;
  localparam logic [1:0] STAGE_OPEN   = 2'd3;

  // Returns min(a + b, 2^width - 1); the sum is formed with a spare carry bit.
  function automatic int unsigned satAdd(input int unsigned a, input int unsigned b,
                                         input int unsigned width);
    logic [32:0] sum;
    logic [32:0] maxVal;
    sum    = {1'b0, a} + {1'b0, b};
    maxVal = (33'd1 << width) - 33'd1;
    return (sum > maxVal) ? maxVal[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/elevator_timer_tick_prescaler.sv
// tick_prescaler: DIV-cycle divider with enable and synchronous clear;
// o_tick flags the last cycle of each period so the owner advances on that edge.
module tick_prescaler #(
  parameter int DIV = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + PW'(1);
  end

  assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/elevator_timer.sv
// elevator_timer: unified floor-travel / door-open timer on the system clock.
// Optional ELEV_TIMER_REOPEN_EN: a delay edge during door ramp-down re-opens the doors.
module elevator_timer
  import elevator_pkg::*;
#(
  parameter int DIV        = 8,
  parameter int CW         = 7,
  parameter int RUN_TICKS  = 6,
  parameter int OPEN_TICKS = 22,
  parameter int EXT_TICKS  = 20
) (
  input  logic          CP,
  input  logic          CR,
  input  logic          StRun,
  input  logic          StOpen,
  input  logic          delay,
  output logic [CW-1:0] count,
  output logic          endRun,
  output logic          endOpen,
  output logic [1:0]    dispStage,
  output logic          busy
);

  localparam logic [CW-1:0] RUN_LAST  = CW'(RUN_TICKS - 1);
  localparam logic [CW-1:0] OPEN_LAST = CW'(OPEN_TICKS - 1);
`ifdef ELEV_TIMER_REOPEN_EN
  localparam logic [CW-1:0] REOPEN_END = CW'(satAdd(3, EXT_TICKS, CW));
`endif

  state_t        r_state, w_nextState;
  logic [CW-1:0] r_count, r_endT, w_nextCount, w_nextEndT, w_extEnd;
  logic [1:0]    r_dispStage, w_nextStage;
  logic          r_endRun, r_endOpen, r_delayPrev;
  logic          w_tick, w_delayEdge, w_runWrap, w_openTerm, w_stateChange;

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .i_clk  (CP),
    .i_rst  (CR),
    .i_en   ((r_state == RUN) || (r_state == OPEN)),
    .i_clr  (w_stateChange),
    .o_tick (w_tick)
  );

  assign w_delayEdge   = delay && !r_delayPrev;
  assign w_runWrap     = (r_state == RUN) && w_tick && (r_count == RUN_LAST);
  assign w_openTerm    = (r_state == OPEN) && w_tick && (r_count == r_endT);
  assign w_stateChange = (w_nextState != r_state);
  assign w_extEnd      = CW'(satAdd(32'(r_endT), EXT_TICKS, CW));

  always_ff @(posedge CP or posedge CR) begin
    if (CR)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (StOpen)     w_nextState = OPEN;
        else if (StRun) w_nextState = RUN;
      end
      RUN:  if (!StRun) w_nextState = IDLE;
      OPEN: begin
        if (!StOpen)         w_nextState = IDLE;
        else if (w_openTerm) w_nextState = DONE;
      end
      DONE: if (!StOpen) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
  end

  // Any state change (including an early abort) restarts count from zero.
  always_comb begin
    w_nextCount = r_count;
    w_nextEndT  = r_endT;
    if (w_stateChange) begin
      w_nextCount = '0;
      if (w_nextState == OPEN) w_nextEndT = OPEN_LAST;
    end else if (r_state == RUN) begin
      if (w_tick) w_nextCount = w_runWrap ? '0 : r_count + CW'(1);
    end else if (r_state == OPEN) begin
      if (w_tick) w_nextCount = r_count + CW'(1);
`ifdef ELEV_TIMER_REOPEN_EN
      if (w_delayEdge && (r_count >= r_endT - CW'(2))) begin
        w_nextCount = CW'(3);
        if (REOPEN_END > r_endT) w_nextEndT = REOPEN_END;
      end else if (w_delayEdge) begin
        w_nextEndT = w_extEnd;
      end
`else
      if (w_delayEdge) w_nextEndT = w_extEnd;
`endif
    end
  end

  always_comb begin
    w_nextStage = STAGE_CLOSED;
    if (w_nextState == OPEN) begin
      if (w_nextCount == CW'(0))                   w_nextStage = STAGE_CLOSED;
      else if (w_nextCount == CW'(1))              w_nextStage = STAGE_AJAR;
      else if (w_nextCount == CW'(2))              w_nextStage = STAGE_HALF;
      else if (w_nextCount == w_nextEndT)          w_nextStage = STAGE_CLOSED;
      else if (w_nextCount == w_nextEndT - CW'(1)) w_nextStage = STAGE_AJAR;
      else if (w_nextCount == w_nextEndT - CW'(2)) w_nextStage = STAGE_HALF;
      else                                         w_nextStage = STAGE_OPEN;
    end
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      r_count     <= '0;
      r_endT      <= OPEN_LAST;
      r_dispStage <= STAGE_CLOSED;
      r_endRun    <= 1'b0;
      r_endOpen   <= 1'b0;
      r_delayPrev <= 1'b0;
    end else begin
      r_count     <= w_nextCount;
      r_endT      <= w_nextEndT;
      r_dispStage <= w_nextStage;
      r_endRun    <= w_runWrap && (w_nextState == RUN);
      r_endOpen   <= w_openTerm && (w_nextState == DONE);
      r_delayPrev <= delay;
    end
  end

  assign count     = r_count;
  assign endRun    = r_endRun;
  assign endOpen   = r_endOpen;
  assign dispStage = r_dispStage;

endmodule

// File: tb/tb_elevator_timer.sv
// tb_elevator_timer: directed stimulus for elevator_timer, checked every cycle
// against an elapsed-cycle model plus hand-computed literal expectations.
module tb_elevator_timer;

  localparam int DIV        = 8;
  localparam int CW         = 7;
  localparam int RUN_TICKS  = 6;
  localparam int OPEN_TICKS = 22;
  localparam int EXT_TICKS  = 20;
  localparam int MAXT       = (1 << CW) - 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_OPEN = 2;
  localparam int M_DONE = 3;

  logic          CP, CR, StRun, StOpen, delay;
  logic [CW-1:0] count;
  logic          endRun, endOpen, busy;
  logic [1:0]    dispStage;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base;
  bit checkEn = 0;

  int mMode, mEl, mEndT;
  bit mEndRun, mEndOpen, mPrevDelay;

  elevator_timer #(
    .DIV(DIV), .CW(CW), .RUN_TICKS(RUN_TICKS),
    .OPEN_TICKS(OPEN_TICKS), .EXT_TICKS(EXT_TICKS)
  ) dut (
    .CP(CP), .CR(CR), .StRun(StRun), .StOpen(StOpen), .delay(delay),
    .count(count), .endRun(endRun), .endOpen(endOpen),
    .dispStage(dispStage), .busy(busy)
  );

  initial begin
    CP = 0;
    forever #5 CP = ~CP;
  end

  always @(posedge CP) cyc <= cyc + 1;

  function automatic int minInt(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Door animation derived directly from position within the open window.
  function automatic int expStage(input int c, input int e);
    if (c <= 2) return c;
    if (c >= e - 2) return e - c;
    return 3;
  endfunction

  // Model: elapsed cycles since entering a mode; count and pulses follow arithmetically.
  always @(posedge CP or posedge CR) begin
    bit dEdge;
    if (CR) begin
      mMode = M_IDLE; mEl = 0; mEndT = OPEN_TICKS - 1;
      mEndRun = 0; mEndOpen = 0; mPrevDelay = 0;
    end else begin
      dEdge = delay && !mPrevDelay;
      mPrevDelay = delay;
      mEndRun = 0;
      mEndOpen = 0;
      case (mMode)
        M_IDLE: begin
          if (StOpen) begin mMode = M_OPEN; mEl = 0; mEndT = OPEN_TICKS - 1; end
          else if (StRun) begin mMode = M_RUN; mEl = 0; end
        end
        M_RUN: begin
          if (!StRun) begin mMode = M_IDLE; mEl = 0; end
          else begin
            mEl++;
            if (mEl % (RUN_TICKS * DIV) == 0) mEndRun = 1;
          end
        end
        M_OPEN: begin
          if (!StOpen) begin mMode = M_IDLE; mEl = 0; end
          else if (mEl + 1 == (mEndT + 1) * DIV) begin
            mMode = M_DONE; mEl = 0; mEndOpen = 1;
          end else begin
`ifdef ELEV_TIMER_REOPEN_EN
            if (dEdge && (mEl / DIV >= mEndT - 2)) begin
              mEl = 3 * DIV + (mEl + 1) % DIV;
              if (minInt(3 + EXT_TICKS, MAXT) > mEndT) mEndT = minInt(3 + EXT_TICKS, MAXT);
            end else begin
              if (dEdge) mEndT = minInt(mEndT + EXT_TICKS, MAXT);
              mEl++;
            end
`else
            if (dEdge) mEndT = minInt(mEndT + EXT_TICKS, MAXT);
            mEl++;
`endif
          end
        end
        M_DONE: if (!StOpen) mMode = M_IDLE;
        default: mMode = M_IDLE;
      endcase
    end
  end

  task automatic expectVal(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkOutput();
    int expCount;
    expCount = 0;
    if (mMode == M_RUN)  expCount = (mEl / DIV) % RUN_TICKS;
    if (mMode == M_OPEN) expCount = mEl / DIV;
    expectVal("model count",     int'(count),     expCount);
    expectVal("model endRun",    int'(endRun),    int'(mEndRun));
    expectVal("model endOpen",   int'(endOpen),   int'(mEndOpen));
    expectVal("model busy",      int'(busy),      (mMode != M_IDLE) ? 1 : 0);
    expectVal("model dispStage", int'(dispStage), (mMode == M_OPEN) ? expStage(expCount, mEndT) : 0);
  endtask

  always @(negedge CP) if (checkEn) checkOutput();

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge CP);
  endtask

  task automatic applyStimulus(input bit run, input bit open);
    StRun = run;
    StOpen = open;
    base = cyc + 1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    CR = 1; StRun = 0; StOpen = 0; delay = 0;
    repeat (3) @(negedge CP);
    expectVal("reset count",     int'(count),     0);
    expectVal("reset busy",      int'(busy),      0);
    expectVal("reset dispStage", int'(dispStage), 0);
    expectVal("reset endRun",    int'(endRun),    0);
    CR = 0;
    checkEn = 1;
    @(negedge CP);

    $display("[TB] continuous run");
    applyStimulus(1, 0);
    waitUntil(base + 10); delay = 1;
    waitUntil(base + 12); delay = 0;
    waitUntil(base + 47);
    expectVal("run endRun @47", int'(endRun), 0);
    expectVal("run count @47",  int'(count),  5);
    waitUntil(base + 48);
    expectVal("run endRun @48", int'(endRun), 1);
    expectVal("run count @48",  int'(count),  0);
    waitUntil(base + 49);
    expectVal("run endRun @49", int'(endRun), 0);
    waitUntil(base + 96);
    expectVal("run endRun @96", int'(endRun), 1);
    waitUntil(base + 100); StRun = 0;
    waitUntil(base + 101);
    expectVal("run stop busy", int'(busy), 0);
    waitUntil(base + 103);

    $display("[TB] door cycle without delay");
    applyStimulus(0, 1);
    waitUntil(base + 8);   expectVal("open stage @8",   int'(dispStage), 1);
    waitUntil(base + 16);  expectVal("open stage @16",  int'(dispStage), 2);
    waitUntil(base + 24);  expectVal("open stage @24",  int'(dispStage), 3);
    waitUntil(base + 152); expectVal("open stage @152", int'(dispStage), 2);
    waitUntil(base + 160); expectVal("open stage @160", int'(dispStage), 1);
    waitUntil(base + 168); expectVal("open stage @168", int'(dispStage), 0);
    waitUntil(base + 175); expectVal("open endOpen @175", int'(endOpen), 0);
    waitUntil(base + 176); expectVal("open endOpen @176", int'(endOpen), 1);
    waitUntil(base + 177); expectVal("open endOpen @177", int'(endOpen), 0);
    waitUntil(base + 180); expectVal("done busy", int'(busy), 1);
    StOpen = 0;
    waitUntil(base + 181); expectVal("done release busy", int'(busy), 0);
    waitUntil(base + 183);

    $display("[TB] door cycle with one delay edge");
    applyStimulus(0, 1);
    waitUntil(base + 80); delay = 1;
    waitUntil(base + 84); delay = 0;
    waitUntil(base + 335);
    expectVal("delay1 count @335",   int'(count),   41);
    expectVal("delay1 endOpen @335", int'(endOpen), 0);
    waitUntil(base + 336);
    expectVal("delay1 endOpen @336", int'(endOpen), 1);
    StOpen = 0;
    waitUntil(base + 339);

    $display("[TB] saturating extension");
    applyStimulus(0, 1);
    for (int i = 0; i < 6; i++) begin
      waitUntil(base + 4 + 4 * i); delay = 1;
      waitUntil(base + 6 + 4 * i); delay = 0;
    end
    waitUntil(base + 1023);
    expectVal("sat count @1023", int'(count), 127);
    waitUntil(base + 1024);
    expectVal("sat endOpen @1024", int'(endOpen), 1);
    expectVal("sat count @1024",   int'(count),   0);
    StOpen = 0;
    waitUntil(base + 1027);

    $display("[TB] simultaneous requests and early abort");
    applyStimulus(1, 1);
    waitUntil(base + 8);
    expectVal("both stage @8", int'(dispStage), 1);
    expectVal("both busy @8",  int'(busy),      1);
    waitUntil(base + 42); StOpen = 0;
    waitUntil(base + 43);
    expectVal("abort busy",      int'(busy),      0);
    expectVal("abort dispStage", int'(dispStage), 0);
    expectVal("abort endOpen",   int'(endOpen),   0);
    StRun = 0;
    waitUntil(base + 46);

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(1, 0);
    waitUntil(base + 26);
    expectVal("prereset count", int'(count), 3);
    #2 CR = 1;
    #1;
    expectVal("async count",  int'(count),  0);
    expectVal("async busy",   int'(busy),   0);
    expectVal("async endRun", int'(endRun), 0);
    @(negedge CP);
    StRun = 0;
    CR = 0;
    repeat (2) @(negedge CP);

    $display("[TB] delay edge during ramp-down");
    applyStimulus(0, 1);
    waitUntil(base + 162); delay = 1;
    waitUntil(base + 163);
`ifdef ELEV_TIMER_REOPEN_EN
    expectVal("reopen count",     int'(count),     3);
    expectVal("reopen dispStage", int'(dispStage), 3);
`else
    expectVal("late count",     int'(count),     20);
    expectVal("late dispStage", int'(dispStage), 3);
`endif
    waitUntil(base + 165); delay = 0;
`ifdef ELEV_TIMER_REOPEN_EN
    waitUntil(base + 328);
    expectVal("reopen endOpen @328", int'(endOpen), 1);
`else
    waitUntil(base + 336);
    expectVal("late endOpen @336", int'(endOpen), 1);
`endif
    StOpen = 0;
    repeat (3) @(negedge CP);

    checkEn = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
